// File: rtl/icache.sv
// icache: direct-mapped cache of 32-bit instruction words serving ifetch.
// Supports halfword-aligned PCs. A 32-bit instruction that straddles two
// words is assembled from both lines, and each missing word is filled in turn.
module icache #(
  parameter int INDEX_BITS = 6
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        to_icache,
  input  logic [31:0] pc_to_icache,
  output logic        have_result,
  output logic [31:0] inst_from_icache,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_done,
  input  logic [31:0] mem_data
);

  localparam int TAG_W = 30 - INDEX_BITS;
  localparam int LINES = 1 << INDEX_BITS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    FILL  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // Registered state and outputs
  state_t            state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic              have_result_q, have_result_d;
  logic [31:0]       inst_q, inst_d;
  logic              mem_req_q, mem_req_d;
  logic [31:0]       mem_addr_q, mem_addr_d;
  logic [LINES-1:0]  valid_q, valid_d;

  // Tag/data storage (not cleared by reset; valid bits gate their use)
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [31:0]       data_q [LINES];

  // Lookup path signals
  logic [31:0]       lk_pc_s;
  logic [31:0]       w0_addr_s, w1_addr_s;
  logic [INDEX_BITS-1:0] idx0_s, idx1_s;
  logic [TAG_W-1:0]  tag0_s, tag1_s;
  logic [31:0]       data0_s, data1_s;
  logic              hit0_s, hit1_s;
  logic [15:0]       half_s;
  logic              compressed_s;
  logic              need_w1_s;
  logic              all_hit_s;
  logic [31:0]       miss_addr_s;
  logic [31:0]       result_s;

  // Fill write port
  logic              fill_we_s;
  logic [INDEX_BITS-1:0] widx_s;
  logic [TAG_W-1:0]  wtag_s;

  // Bits that are structurally constant or never needed
  logic              unused_s;
  assign unused_s = ^{lk_pc_s[0], w0_addr_s[1:0], w1_addr_s[1:0]};

  assign have_result      = have_result_q;
  assign inst_from_icache = inst_q;
  assign mem_req          = mem_req_q;
  assign mem_addr         = mem_addr_q;

  // Tag/valid lookup of both candidate words and assembly of the result word
  always_comb begin
    if (state_q == IDLE) begin
      lk_pc_s = pc_to_icache;
    end else begin
      lk_pc_s = pc_q;
    end
    w0_addr_s = {lk_pc_s[31:2], 2'b00};
    w1_addr_s = w0_addr_s + 32'd4;
    idx0_s    = w0_addr_s[INDEX_BITS+1:2];
    idx1_s    = w1_addr_s[INDEX_BITS+1:2];
    tag0_s    = w0_addr_s[31:INDEX_BITS+2];
    tag1_s    = w1_addr_s[31:INDEX_BITS+2];
    data0_s   = data_q[idx0_s];
    data1_s   = data_q[idx1_s];
    hit0_s    = valid_q[idx0_s] && (tag_q[idx0_s] == tag0_s);
    hit1_s    = valid_q[idx1_s] && (tag_q[idx1_s] == tag1_s);
    if (lk_pc_s[1]) begin
      half_s = data0_s[31:16];
    end else begin
      half_s = data0_s[15:0];
    end
    compressed_s = (half_s[1:0] != 2'b11);
    need_w1_s    = lk_pc_s[1] && !compressed_s;
    all_hit_s    = hit0_s && (!need_w1_s || hit1_s);
    // w0 is always fetched before w1
    if (!hit0_s) begin
      miss_addr_s = w0_addr_s;
    end else begin
      miss_addr_s = w1_addr_s;
    end
    if (!lk_pc_s[1]) begin
      result_s = data0_s;
    end else if (compressed_s) begin
      result_s = {16'h0000, data0_s[31:16]};
    end else begin
      result_s = {data1_s[15:0], data0_s[31:16]};
    end
  end

  // Fill write port: the returned word lands at the line addressed by mem_addr
  always_comb begin
    fill_we_s = (state_q == FILL) && mem_done && rdy_in;
    widx_s    = mem_addr_q[INDEX_BITS+1:2];
    wtag_s    = mem_addr_q[31:INDEX_BITS+2];
  end

  // Controller next-state and registered-output logic
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    have_result_d = 1'b0;
    inst_d        = inst_q;
    mem_req_d     = mem_req_q;
    mem_addr_d    = mem_addr_q;
    valid_d       = valid_q;
    case (state_q)
      IDLE: begin
        if (to_icache) begin
          pc_d = pc_to_icache;
          if (all_hit_s) begin
            have_result_d = 1'b1;
            inst_d        = result_s;
          end else begin
            state_d    = FILL;
            mem_req_d  = 1'b1;
            mem_addr_d = miss_addr_s;
          end
        end else begin
          state_d = IDLE;
        end
      end
      FILL: begin
        if (mem_done) begin
          valid_d[widx_s] = 1'b1;
          mem_req_d       = 1'b0;
          state_d         = CHECK;
        end else begin
          mem_req_d = 1'b1;
        end
      end
      CHECK: begin
        if (all_hit_s) begin
          state_d = RESP;
        end else begin
          state_d    = FILL;
          mem_req_d  = 1'b1;
          mem_addr_d = miss_addr_s;
        end
      end
      RESP: begin
        have_result_d = 1'b1;
        inst_d        = result_s;
        state_d       = IDLE;
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // State and output registers; rdy_in low freezes everything
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q       <= IDLE;
      pc_q          <= 32'h0000_0000;
      have_result_q <= 1'b0;
      inst_q        <= 32'h0000_0000;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= 32'h0000_0000;
      valid_q       <= {LINES{1'b0}};
    end else if (rdy_in) begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      have_result_q <= have_result_d;
      inst_q        <= inst_d;
      mem_req_q     <= mem_req_d;
      mem_addr_q    <= mem_addr_d;
      valid_q       <= valid_d;
    end
  end

  // Tag/data array write on fill completion, same cycle as the valid set
  always_ff @(posedge clk_in) begin
    if (fill_we_s && !rst_in) begin
      tag_q[widx_s]  <= wtag_s;
      data_q[widx_s] <= mem_data;
    end
  end

endmodule
